// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road signal sequencer with pedestrian green shortening.
// Define TL_NIGHT_MODE_EN to enable the night-mode flashing-yellow BLINK state.
module traffic_light_ctrl #(
  parameter int CNT_W     = 4,
  parameter int G_TIME    = 15,
  parameter int Y_TIME    = 5,
  parameter int R_TIME    = 2,
  parameter int PED_SHORT = 3
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             ped_req,
  input  logic             night,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] value,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic             ped_ack
);
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    BLINK = 3'd6
  } state_t;
  localparam logic [1:0] GREEN = 2'd0;
  localparam logic [1:0] YELLO = 2'd1;
  localparam logic [1:0] RED   = 2'd2;
  localparam logic [1:0] OFF   = 2'd3;
  localparam logic [CNT_W-1:0] G_LD = CNT_W'(G_TIME - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] R_LD = CNT_W'(R_TIME - 1);
  localparam logic [CNT_W-1:0] PS   = CNT_W'(PED_SHORT);
`ifdef TL_NIGHT_MODE_EN
  localparam logic NIGHT_EN = 1'b1;
`else
  localparam logic NIGHT_EN = 1'b0;
`endif
  state_t           state_q, state_d, nxt;
  logic [CNT_W-1:0] value_q, value_d;
  logic             pend_q, pend_d, ack_q, ack_d, blink_q, blink_d;
  logic             pend, green, phase_end, night_go;
  // A request arriving this cycle counts immediately, so the green is cut on the next edge
  assign pend      = pend_q | ped_req;
  assign green     = (state_q == NS_G) || (state_q == EW_G);
  assign phase_end = value_q == '0;
  assign night_go  = NIGHT_EN & night;
  always_comb begin
    nxt = NS_G;
    case (state_q)
      NS_G:    nxt = NS_Y;
      NS_Y:    nxt = AR1;
      AR1:     nxt = EW_G;
      EW_G:    nxt = EW_Y;
      EW_Y:    nxt = AR2;
      default: nxt = NS_G;
    endcase
  end
  always_comb begin
    state_d = state_q;
    value_d = value_q - CNT_W'(1);
    ack_d   = 1'b0;
    blink_d = 1'b0;
    if (NIGHT_EN && state_q == BLINK) begin
      state_d = night ? BLINK : AR2;
      value_d = night ? '0 : R_LD;
      blink_d = night & ~blink_q;
    end else if (state_q > AR2) begin
      state_d = NS_G;
      value_d = G_LD;
    end else if (phase_end) begin
      state_d = night_go ? BLINK : nxt;
      value_d = night_go ? '0 :
                (nxt == NS_G || nxt == EW_G) ? G_LD :
                (nxt == NS_Y || nxt == EW_Y) ? Y_LD : R_LD;
      ack_d   = green & pend & ~night_go;
    end else if (green && pend && value_q > PS) begin
      value_d = PS;
    end
    pend_d = ped_req | (pend_q & ~ack_d);
  end
  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) begin
      state_q <= NS_G;
      value_q <= G_LD;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      blink_q <= blink_d;
    end
  end
  assign status   = state_q;
  assign value    = value_q;
  assign ped_ack  = ack_q;
  assign ns_light = state_q == NS_G  ? GREEN :
                    state_q == NS_Y  ? YELLO :
                    state_q == BLINK ? (blink_q ? OFF : YELLO) : RED;
  assign ew_light = state_q == EW_G  ? GREEN :
                    state_q == EW_Y  ? YELLO :
                    state_q == BLINK ? (blink_q ? OFF : YELLO) : RED;
endmodule
